// File: rtl/pg_flow_scheduler.sv
// ---------------------------------------------------------------------------
// pg_flow_scheduler
//
// Token-bucket rate scheduler placed in front of the packet generator's frame
// builder. Every cycle each enabled flow earns byte credit at its configured
// rate, with the credit capped at BURST_BYTES. A round-robin picker offers the
// next eligible flow, together with its frame size, on a valid/ready
// handshake. When the grant is accepted, that frame size is deducted from the
// flow's bucket. Over time each flow's output therefore tracks its configured
// bandwidth.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   cfg_enable   per-flow enable
//   cfg_rate     per-flow rate; flow i at [i*RATE_W +: RATE_W]; unsigned
//                fixed point with FRAC_BITS fractional bits, unit bytes/cycle
//   cfg_size     per-flow frame size in bytes; flow i at [i*SIZE_W +: SIZE_W]
//   sched_valid  grant offered
//   sched_ready  frame builder accepts the grant
//   sched_flow   granted flow index
//   sched_size   granted frame size
//   grant_count  total accepted grants (wraps)
//   credit_sat   sticky per-flow flag: credit hit the cap; cleared by reset
// ---------------------------------------------------------------------------
module pg_flow_scheduler #(
    parameter  int N_FLOWS     = 4,
    parameter  int SIZE_W      = 11,
    parameter  int RATE_W      = 24,
    parameter  int FRAC_BITS   = 16,
    parameter  int CREDIT_W    = 32,
    parameter  int BURST_BYTES = 4096,
    localparam int FLOW_W      = $clog2(N_FLOWS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_FLOWS-1:0]          cfg_enable,
    input  logic [N_FLOWS*RATE_W-1:0]   cfg_rate,
    input  logic [N_FLOWS*SIZE_W-1:0]   cfg_size,
    output logic                        sched_valid,
    input  logic                        sched_ready,
    output logic [FLOW_W-1:0]           sched_flow,
    output logic [SIZE_W-1:0]           sched_size,
    output logic [31:0]                 grant_count,
    output logic [N_FLOWS-1:0]          credit_sat
);

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    localparam logic [CREDIT_W:0] CAP = (CREDIT_W+1)'(BURST_BYTES) << FRAC_BITS;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [CREDIT_W-1:0]    r_credit [N_FLOWS];
    logic [FLOW_W-1:0]      r_rrPtr;
    logic [FLOW_W-1:0]      r_flow;
    logic [SIZE_W-1:0]      r_size;
    logic [31:0]            r_grantCount;
    logic [N_FLOWS-1:0]     r_creditSat;

    logic                   w_handshake;
    logic [N_FLOWS-1:0]     w_elig;
    logic [N_FLOWS-1:0]     w_over;
    logic [CREDIT_W:0]      w_net [N_FLOWS];
    logic                   w_anyElig;
    logic [FLOW_W-1:0]      w_sel;
    logic [FLOW_W-1:0]      w_rrNext;

    assign w_handshake = (r_state == ST_OFFER) && sched_ready;

    // Per-flow bucket arithmetic and eligibility. The sum is computed one bit
    // wider than the credit so that the clamp against CAP sees a true
    // overflow. A flow that was disabled and then re-enabled during an offer
    // can hold less credit than the latched size. In that case the result
    // floors at zero rather than wrapping.
    always_comb begin
        logic [CREDIT_W:0] v_add;
        logic [CREDIT_W:0] v_deduct;
        logic [CREDIT_W:0] v_need;
        logic [SIZE_W-1:0] v_size;
        w_elig = '0;
        w_over = '0;
        for (int i = 0; i < N_FLOWS; i++) begin
            v_size   = cfg_size[i*SIZE_W +: SIZE_W];
            v_add    = {1'b0, r_credit[i]} + (CREDIT_W+1)'(cfg_rate[i*RATE_W +: RATE_W]);
            v_deduct = '0;
            if (w_handshake && (r_flow == FLOW_W'(i))) begin
                v_deduct = (CREDIT_W+1)'(r_size) << FRAC_BITS;
            end
            if (v_add < v_deduct) begin
                w_net[i] = '0;
            end else begin
                w_net[i] = v_add - v_deduct;
            end
            w_over[i] = (w_net[i] > CAP);
            v_need    = (CREDIT_W+1)'(v_size) << FRAC_BITS;
            w_elig[i] = cfg_enable[i] && (v_size != '0) && ({1'b0, r_credit[i]} >= v_need);
        end
    end

    // Round-robin pick. The scan starts at r_rrPtr and wraps modulo N_FLOWS,
    // so N_FLOWS does not need to be a power of two.
    always_comb begin
        int v_idx;
        w_anyElig = 1'b0;
        w_sel     = '0;
        for (int k = 0; k < N_FLOWS; k++) begin
            v_idx = (int'(r_rrPtr) + k) % N_FLOWS;
            if (!w_anyElig && w_elig[v_idx]) begin
                w_anyElig = 1'b1;
                w_sel     = FLOW_W'(v_idx);
            end
        end
    end

    assign w_rrNext = (r_flow == FLOW_W'(N_FLOWS-1)) ? '0 : r_flow + 1'b1;

    // Next-state and output decode. sched_valid is decoded from the state
    // register, so an asynchronous reset removes the offer at once.
    always_comb begin
        w_nextState = r_state;
        sched_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyElig) begin
                    w_nextState = ST_OFFER;
                end
            end
            ST_OFFER: begin
                sched_valid = 1'b1;
                if (sched_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant latch, round-robin pointer and grant counter. The flow and size
    // are captured once on entry to OFFER. Later cfg_size changes therefore
    // cannot disturb an offer that is already outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flow       <= '0;
            r_size       <= '0;
            r_rrPtr      <= '0;
            r_grantCount <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_anyElig) begin
                r_flow <= w_sel;
                r_size <= cfg_size[w_sel*SIZE_W +: SIZE_W];
            end
            if (w_handshake) begin
                r_rrPtr      <= w_rrNext;
                r_grantCount <= r_grantCount + 32'd1;
            end
        end
    end

    // Credit buckets and sticky saturation flags. A disabled flow is held at
    // zero, which also discards any deduction aimed at it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_FLOWS; i++) begin
                r_credit[i] <= '0;
            end
            r_creditSat <= '0;
        end else begin
            for (int i = 0; i < N_FLOWS; i++) begin
                if (!cfg_enable[i]) begin
                    r_credit[i] <= '0;
                end else if (w_over[i]) begin
                    r_credit[i]    <= CAP[CREDIT_W-1:0];
                    r_creditSat[i] <= 1'b1;
                end else begin
                    r_credit[i] <= w_net[i][CREDIT_W-1:0];
                end
            end
        end
    end

    assign sched_flow  = r_flow;
    assign sched_size  = r_size;
    assign grant_count = r_grantCount;
    assign credit_sat  = r_creditSat;

endmodule

// File: tb/tb_pg_flow_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pg_flow_scheduler
//
// Directed bench for pg_flow_scheduler. The expected values are worked out by
// hand from the token-bucket arithmetic. The DUT is built with SIZE_W=13 so
// that a 5000-byte frame, which is larger than the burst cap, can actually be
// configured.
// ---------------------------------------------------------------------------
module tb_pg_flow_scheduler;

    localparam int N  = 4;
    localparam int SW = 13;
    localparam int RW = 24;
    localparam logic [31:0] CAP = 32'h1000_0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    cfgEnable;
    logic [N*RW-1:0] cfgRate;
    logic [N*SW-1:0] cfgSize;
    logic            schedValid;
    logic            schedReady;
    logic [1:0]      schedFlow;
    logic [SW-1:0]   schedSize;
    logic [31:0]     grantCount;
    logic [N-1:0]    creditSat;

    int passCount  = 0;
    int checkCount = 0;
    int n;
    bit f;

    pg_flow_scheduler #(.N_FLOWS(N), .SIZE_W(SW)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .cfg_enable  (cfgEnable),
        .cfg_rate    (cfgRate),
        .cfg_size    (cfgSize),
        .sched_valid (schedValid),
        .sched_ready (schedReady),
        .sched_flow  (schedFlow),
        .sched_size  (schedSize),
        .grant_count (grantCount),
        .credit_sat  (creditSat)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Program the configuration of one flow
    task automatic applyStimulus(input int flow, input logic en, input logic [RW-1:0] rate, input logic [SW-1:0] size);
        cfgEnable[flow]          = en;
        cfgRate[flow*RW +: RW]   = rate;
        cfgSize[flow*SW +: SW]   = size;
    endtask

    // Advance one clock; outputs are sampled on the falling edge
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with every flow disabled and ready low
    task automatic doReset();
        rst_n      = 1'b0;
        schedReady = 1'b0;
        cfgEnable  = '0;
        cfgRate    = '0;
        cfgSize    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait a bounded number of cycles for sched_valid
    task automatic waitValid(input int maxCycles, output int cycles, output bit found);
        cycles = 0;
        found  = 1'b0;
        while (cycles < maxCycles && !found) begin
            stepCycle();
            cycles++;
            if (schedValid) found = 1'b1;
        end
    endtask

    initial begin
        int hs, rotErr, expFlow, holdErr, cnt0, cnt2, cntV;

        // ---- reset state ----
        rst_n      = 1'b0;
        schedReady = 1'b0;
        cfgEnable  = '0;
        cfgRate    = '0;
        cfgSize    = '0;
        #1;
        checkOutput("rst_valid", schedValid, 0);
        checkOutput("rst_flow", schedFlow, 0);
        checkOutput("rst_size", schedSize, 0);
        checkOutput("rst_count", grantCount, 0);
        checkOutput("rst_sat", creditSat, 0);
        doReset();

        // ---- single flow at 0.5 B/cycle, 64-byte frames ----
        schedReady = 1'b1;
        applyStimulus(0, 1'b1, 24'h008000, 64);
        waitValid(300, n, f);
        checkOutput("t1_found", f, 1);
        checkOutput("t1_latency", n, 129);
        checkOutput("t1_flow", schedFlow, 0);
        checkOutput("t1_size", schedSize, 64);
        checkOutput("t1_count0", grantCount, 0);
        waitValid(300, n, f);
        checkOutput("t1_found2", f, 1);
        checkOutput("t1_interval", n, 128);
        checkOutput("t1_count1", grantCount, 1);
        stepCycle();
        checkOutput("t1_count2", grantCount, 2);

        // ---- four flows at 16 B/cycle, round robin ----
        doReset();
        schedReady = 1'b1;
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 24'h100000, 64);
        hs = 0; rotErr = 0; expFlow = 0;
        repeat (400) begin
            stepCycle();
            if (schedValid) begin
                hs++;
                if (int'(schedFlow) != expFlow) rotErr++;
                expFlow = (expFlow + 1) % N;
            end
        end
        checkOutput("t2_rotation", rotErr, 0);
        checkOutput("t2_hs", hs, 198);
        checkOutput("t2_count", grantCount, hs);

        // ---- long hold with ready low, saturation, latched size ----
        doReset();
        applyStimulus(1, 1'b1, 24'h010000, 100);
        waitValid(300, n, f);
        checkOutput("t3_found", f, 1);
        checkOutput("t3_latency", n, 101);
        holdErr = 0;
        for (int i = 0; i < 5000; i++) begin
            if (i == 10) cfgSize[1*SW +: SW] = 200;
            stepCycle();
            if (!schedValid || schedFlow != 2'd1 || schedSize != 100) holdErr++;
        end
        checkOutput("t3_hold", holdErr, 0);
        checkOutput("t3_credit_cap", dut.r_credit[1], CAP);
        checkOutput("t3_sat", creditSat, 4'b0010);
        schedReady = 1'b1;
        stepCycle();
        checkOutput("t3_credit_after", dut.r_credit[1], CAP - (32'd100 << 16) + 32'h0001_0000);
        checkOutput("t3_count", grantCount, 1);
        schedReady = 1'b0;

        // ---- oversized frame on flow 2 never granted ----
        doReset();
        schedReady = 1'b1;
        applyStimulus(0, 1'b1, 24'h100000, 64);
        applyStimulus(2, 1'b1, 24'h400000, 5000);
        cnt0 = 0; cnt2 = 0;
        repeat (300) begin
            stepCycle();
            if (schedValid && schedFlow == 2'd0) cnt0++;
            if (schedValid && schedFlow == 2'd2) cnt2++;
        end
        checkOutput("t4_flow2", cnt2, 0);
        checkOutput("t4_flow0", cnt0, 74);
        checkOutput("t4_sat", creditSat, 4'b0100);

        // ---- disable the granted flow while it is offered ----
        doReset();
        applyStimulus(0, 1'b1, 24'h100000, 64);
        waitValid(50, n, f);
        checkOutput("t5_found", f, 1);
        cfgEnable[0] = 1'b0;
        stepCycle();
        checkOutput("t5_held_valid", schedValid, 1);
        checkOutput("t5_held_flow", schedFlow, 0);
        schedReady = 1'b1;
        stepCycle();
        checkOutput("t5_count", grantCount, 1);
        checkOutput("t5_credit", dut.r_credit[0], 0);
        cntV = 0;
        repeat (50) begin
            stepCycle();
            if (schedValid) cntV++;
        end
        checkOutput("t5_no_grants", cntV, 0);
        checkOutput("t5_credit_stays", dut.r_credit[0], 0);

        // ---- reset pulsed mid-offer ----
        doReset();
        schedReady = 1'b1;
        applyStimulus(0, 1'b1, 24'h100000, 64);
        applyStimulus(1, 1'b1, 24'h100000, 64);
        waitValid(50, n, f);
        checkOutput("t6_first_flow", schedFlow, 0);
        stepCycle();
        schedReady = 1'b0;
        waitValid(50, n, f);
        checkOutput("t6_found", f, 1);
        checkOutput("t6_offer_flow", schedFlow, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", schedValid, 0);
        checkOutput("t6_async_count", grantCount, 0);
        checkOutput("t6_async_flow", schedFlow, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        schedReady = 1'b1;
        waitValid(50, n, f);
        checkOutput("t6_restart_found", f, 1);
        checkOutput("t6_restart_flow", schedFlow, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
